// File: rtl/i2c_defs.sv
// rtl/i2c_defs.sv - shared state encodings and field positions for the I2C-to-CSR bridge
package i2c_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_WDATA,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } state_e;

    // Sub-phase within a byte-carrying state: shifting bits, or the two halves of the ACK slot.
    typedef enum logic [1:0] {
        PH_BYTE,
        PH_ACK_SETUP,
        PH_ACK_HOLD
    } phase_e;

    localparam int         RW_BIT   = 0;
    localparam logic [2:0] LAST_BIT = 3'd7;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizers with edge, START and STOP decode
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda
);

    // [0],[1] are the synchronizer stages, [2] is the history bit used for edge decode.
    logic [2:0] scl_q;
    logic [2:0] sda_q;
    logic [2:0] scl_d;
    logic [2:0] sda_d;

    assign scl_d = {scl_q[1:0], scl_i};
    assign sda_d = {sda_q[1:0], sda_i};

    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

    // SCL must be high in both samples, so a simultaneous SDA/SCL change is just data.
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    assign sda      = sda_q[1];

endmodule

// File: rtl/i2c_csr_bridge.sv
// rtl/i2c_csr_bridge.sv - I2C target that masters the internal CSR bus
module i2c_csr_bridge
    import i2c_defs::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h4a
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [4:0] csr_a,
    output logic [7:0] csr_di,
    output logic       csr_we,
    input  logic [7:0] csr_do
);

    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda_s;

    i2c_line_sync u_line_sync (
        .clk     (clk),
        .rst     (rst),
        .scl_i   (scl_i),
        .sda_i   (sda_i),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop),
        .sda     (sda_s)
    );

    state_e     state_q,    state_d;
    phase_e     phase_q,    phase_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [6:0] shift_q,    shift_d;
    logic [7:0] tx_q,       tx_d;
    logic [4:0] ptr_q,      ptr_d;
    logic       sda_oe_q,   sda_oe_d;
    logic       csr_we_q,   csr_we_d;
    logic [7:0] csr_di_q,   csr_di_d;
    logic       rw_q,       rw_d;
    logic       nack_q,     nack_d;

    logic [7:0] shift_in;
    logic       last_bit;

    assign shift_in = {shift_q, sda_s};
    assign last_bit = (bit_cnt_q == LAST_BIT);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        csr_we_d  = 1'b0;
        csr_di_d  = csr_di_q;
        rw_d      = rw_q;
        nack_d    = nack_q;

        // The pointer advances the cycle after the write strobe so csr_a is stable under it.
        if (csr_we_q) begin
            ptr_d = ptr_q + 5'd1;
        end

        if (start) begin
            state_d   = ST_ADDR;
            phase_d   = PH_BYTE;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else if (stop) begin
            state_d   = ST_IDLE;
            phase_d   = PH_BYTE;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = shift_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            if (shift_in[7:1] == I2C_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                phase_d = PH_ACK_SETUP;
                                rw_d    = shift_in[RW_BIT];
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (phase_q == PH_ACK_SETUP) begin
                            sda_oe_d = 1'b1;
                            phase_d  = PH_ACK_HOLD;
                        end else begin
                            phase_d   = PH_BYTE;
                            bit_cnt_d = 3'd0;
                            if (rw_q) begin
                                state_d  = ST_RDATA;
                                tx_d     = {csr_do[6:0], 1'b1};
                                sda_oe_d = ~csr_do[7];
                            end else begin
                                state_d  = ST_PTR;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end

                ST_PTR, ST_WDATA: begin
                    if (phase_q == PH_BYTE) begin
                        if (scl_rise) begin
                            shift_d   = shift_in[6:0];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (last_bit) begin
                                phase_d = PH_ACK_SETUP;
                                if (state_q == ST_PTR) begin
                                    ptr_d = shift_in[4:0];
                                end else begin
                                    csr_we_d = 1'b1;
                                    csr_di_d = shift_in;
                                end
                            end
                        end
                    end else if (scl_fall) begin
                        if (phase_q == PH_ACK_SETUP) begin
                            sda_oe_d = 1'b1;
                            phase_d  = PH_ACK_HOLD;
                        end else begin
                            sda_oe_d  = 1'b0;
                            phase_d   = PH_BYTE;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_WDATA;
                        end
                    end
                end

                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            ptr_d   = ptr_q + 5'd1;
                            state_d = ST_RDATA_ACK;
                            phase_d = PH_ACK_SETUP;
                        end
                    end else if (scl_fall) begin
                        sda_oe_d = ~tx_q[7];
                        tx_d     = {tx_q[6:0], 1'b1};
                    end
                end

                ST_RDATA_ACK: begin
                    if (phase_q == PH_ACK_SETUP) begin
                        if (scl_fall) begin
                            sda_oe_d = 1'b0;
                        end
                        if (scl_rise) begin
                            nack_d  = sda_s;
                            phase_d = PH_ACK_HOLD;
                        end
                    end else if (scl_fall) begin
                        phase_d   = PH_BYTE;
                        bit_cnt_d = 3'd0;
                        if (!nack_q) begin
                            state_d  = ST_RDATA;
                            tx_d     = {csr_do[6:0], 1'b1};
                            sda_oe_d = ~csr_do[7];
                        end else begin
                            state_d  = ST_WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= PH_BYTE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
            tx_q      <= 8'hff;
            ptr_q     <= 5'd0;
            sda_oe_q  <= 1'b0;
            csr_we_q  <= 1'b0;
            csr_di_q  <= 8'd0;
            rw_q      <= 1'b0;
            nack_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            csr_we_q  <= csr_we_d;
            csr_di_q  <= csr_di_d;
            rw_q      <= rw_d;
            nack_q    <= nack_d;
        end
    end

    assign sda_oe = sda_oe_q;
    assign csr_a  = ptr_q;
    assign csr_di = csr_di_q;
    assign csr_we = csr_we_q;

endmodule
